// File: rtl/mem_pkg.sv
// Shared types and constants for the non-blocking MEM pipeline stage.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ms_state_e;

  // Bit positions inside the one-hot ld_op vector {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data alignment: shifts the addressed byte/half down and sign/zero-extends it.
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [4:0]      ld_op,
  output logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    wdata   = shifted;
    if (ld_op[LD_B]) begin
      wdata = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
    end else if (ld_op[LD_BU]) begin
      wdata = {{(XLEN-8){1'b0}}, shifted[7:0]};
    end else if (ld_op[LD_H]) begin
      wdata = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
    end else if (ld_op[LD_HU]) begin
      wdata = {{(XLEN-16){1'b0}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/mem_stage_nb.sv
// MEM pipeline stage with non-blocking data-SRAM responses, an outstanding-request
// counter, and a discard counter that drops responses belonging to flushed requests.
module mem_stage_nb
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int XLEN            = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            es_to_ms_valid,
  output logic            ms_allowin,
  input  logic [XLEN-1:0] es_pc,
  input  logic [XLEN-1:0] es_result,
  input  logic            es_rf_we,
  input  logic [4:0]      es_rf_waddr,
  input  logic            es_res_from_mem,
  input  logic [4:0]      es_ld_op,
  input  logic            es_mem_req,
  input  logic            es_ex,
  input  logic            req_issue,
  output logic            req_block,
  input  logic            data_sram_data_ok,
  input  logic [XLEN-1:0] data_sram_rdata,
  input  logic            flush,
  input  logic            ws_allowin,
  output logic            ms_to_ws_valid,
  output logic [XLEN-1:0] ms_pc,
  output logic            ms_rf_we,
  output logic [4:0]      ms_rf_waddr,
  output logic [XLEN-1:0] ms_rf_wdata,
  output logic            ms_res_from_mem,
  output logic            ms_ex,
  output ms_state_e       dbg_state,
  output logic [2:0]      dbg_count,
  output logic [2:0]      dbg_discard
);

  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);

  ms_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] pc_q, result_q;
  logic            rf_we_q, res_from_mem_q, ex_q;
  logic [4:0]      rf_waddr_q, ld_op_q;

  logic            valid;
  logic            data_ok_acc;
  logic            transfer_in;
  logic [XLEN-1:0] load_src;
  logic [XLEN-1:0] load_wdata;

  // Responses still owed to flushed requests are swallowed before any reach the stage.
  assign data_ok_acc    = data_sram_data_ok && (discard_q == '0);
  assign valid          = (state_q != ST_EMPTY);
  assign ms_to_ws_valid = (state_q == ST_READY) || ((state_q == ST_WAIT) && data_ok_acc);
  assign ms_allowin     = (state_q == ST_EMPTY) || (ms_to_ws_valid && ws_allowin);
  assign transfer_in    = es_to_ms_valid && ms_allowin;
  assign req_block      = (count_q == CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q + CNT_W'(req_issue) - CNT_W'(data_sram_data_ok);
    discard_d = discard_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else if (transfer_in) begin
      state_d = (es_mem_req && !es_ex) ? ST_WAIT : ST_READY;
    end else if (ms_to_ws_valid && ws_allowin) begin
      state_d = ST_EMPTY;
    end else if ((state_q == ST_WAIT) && data_ok_acc) begin
      state_d = ST_READY;
    end

    if ((state_q == ST_WAIT) && data_ok_acc) begin
      hold_d = data_sram_rdata;
    end

    if (flush) begin
      discard_d = count_d;
    end else if (data_sram_data_ok && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_EMPTY;
      count_q        <= '0;
      discard_q      <= '0;
      hold_q         <= '0;
      pc_q           <= '0;
      result_q       <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= '0;
      ex_q           <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
      if (transfer_in && !flush) begin
        pc_q           <= es_pc;
        result_q       <= es_result;
        rf_we_q        <= es_rf_we;
        rf_waddr_q     <= es_rf_waddr;
        res_from_mem_q <= es_res_from_mem;
        ld_op_q        <= es_ld_op;
        ex_q           <= es_ex;
      end
    end
  end

  // In WAIT the response is forwarded straight from the SRAM; afterwards from the hold register.
  assign load_src = (state_q == ST_WAIT) ? data_sram_rdata : hold_q;

  mem_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata (load_src),
    .addr  (result_q[1:0]),
    .ld_op (ld_op_q),
    .wdata (load_wdata)
  );

  assign ms_pc           = pc_q;
  assign ms_rf_waddr     = rf_waddr_q;
  assign ms_rf_we        = rf_we_q && valid;
  assign ms_res_from_mem = res_from_mem_q && valid;
  assign ms_ex           = ex_q && valid;
  assign ms_rf_wdata     = res_from_mem_q ? load_wdata : result_q;

  assign dbg_state   = state_q;
  assign dbg_count   = 3'(count_q);
  assign dbg_discard = 3'(discard_q);

endmodule

// File: tb/tb_mem_stage_nb.sv
// Directed bench for mem_stage_nb: load extension, back-pressure hold, counters, flush discard, reset.
module tb_mem_stage_nb;
  import mem_pkg::*;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc, es_result;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic        es_res_from_mem;
  logic [4:0]  es_ld_op;
  logic        es_mem_req, es_ex;
  logic        req_issue, req_block;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush, ws_allowin, ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_res_from_mem, ms_ex;
  ms_state_e   dbg_state;
  logic [2:0]  dbg_count, dbg_discard;

  int total = 0;
  int bad   = 0;

  mem_stage_nb #(.MAX_OUTSTANDING(2), .XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_result(es_result),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_res_from_mem(es_res_from_mem),
    .es_ld_op(es_ld_op), .es_mem_req(es_mem_req), .es_ex(es_ex),
    .req_issue(req_issue), .req_block(req_block),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .ms_res_from_mem(ms_res_from_mem), .ms_ex(ms_ex),
    .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_discard(dbg_discard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid    = 1'b0;
    es_pc             = '0;
    es_result         = '0;
    es_rf_we          = 1'b0;
    es_rf_waddr       = '0;
    es_res_from_mem   = 1'b0;
    es_ld_op          = '0;
    es_mem_req        = 1'b0;
    es_ex             = 1'b0;
    req_issue         = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    flush             = 1'b0;
    ws_allowin        = 1'b1;
  endtask

  task automatic drive_load(input logic [4:0] op, input logic [31:0] addr, input logic [4:0] rd);
    es_to_ms_valid  = 1'b1;
    es_pc           = 32'h0000_1000 + addr;
    es_result       = addr;
    es_rf_we        = 1'b1;
    es_rf_waddr     = rd;
    es_res_from_mem = 1'b1;
    es_ld_op        = op;
    es_mem_req      = 1'b1;
    es_ex           = 1'b0;
  endtask

  // Issue, transfer, then respond one cycle later with ws_allowin=1.
  task automatic do_load(input string tag, input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    idle(); req_issue = 1'b1; #1; tick();
    idle(); drive_load(op, addr, 5'd7); #1; tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = rdata; #1;
    check({tag, "_valid"}, 32'(ms_to_ws_valid), 32'd1);
    check({tag, "_wdata"}, ms_rf_wdata, exp);
    tick(); idle(); #1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1; #1;
    check("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    check("rst_allowin", 32'(ms_allowin), 32'd1);
    check("rst_block", 32'(req_block), 32'd0);
    check("rst_ex", 32'(ms_ex), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_EMPTY));
    check("rst_count", 32'(dbg_count), 32'd0);

    // ld_b at addr ...3, data_ok three cycles after entry
    req_issue = 1'b1; #1; tick();
    idle(); drive_load(5'b10000, 32'h0000_2003, 5'd5); #1;
    check("lb_allowin", 32'(ms_allowin), 32'd1);
    tick(); idle(); #1;
    check("lb_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("lb_rf_we_fwd", 32'(ms_rf_we), 32'd1);
    check("lb_wait1_valid", 32'(ms_to_ws_valid), 32'd0);
    tick(); #1;
    check("lb_wait2_valid", 32'(ms_to_ws_valid), 32'd0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8011_2233; #1;
    check("lb_valid", 32'(ms_to_ws_valid), 32'd1);
    check("lb_wdata", ms_rf_wdata, 32'hFFFF_FF80);
    check("lb_waddr", 32'(ms_rf_waddr), 32'd5);
    tick(); idle(); #1;
    check("lb_state_empty", 32'(dbg_state), 32'(ST_EMPTY));
    check("lb_count", 32'(dbg_count), 32'd0);

    // back-pressure: data_ok with ws_allowin=0 for 4 cycles, rdata changes afterwards
    req_issue = 1'b1; #1; tick();
    idle(); drive_load(5'b00001, 32'h0000_0100, 5'd9); #1; tick();
    idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_BABE; #1;
    check("bp_c0_valid", 32'(ms_to_ws_valid), 32'd1);
    check("bp_c0_allowin", 32'(ms_allowin), 32'd0);
    check("bp_c0_wdata", ms_rf_wdata, 32'hCAFE_BABE);
    for (int i = 1; i < 4; i++) begin
      tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; #1;
      check($sformatf("bp_c%0d_state", i), 32'(dbg_state), 32'(ST_READY));
      check($sformatf("bp_c%0d_wdata", i), ms_rf_wdata, 32'hCAFE_BABE);
      check($sformatf("bp_c%0d_allowin", i), 32'(ms_allowin), 32'd0);
    end
    tick(); ws_allowin = 1'b1; #1;
    check("bp_rel_allowin", 32'(ms_allowin), 32'd1);
    check("bp_rel_wdata", ms_rf_wdata, 32'hCAFE_BABE);
    tick(); idle(); #1;
    check("bp_state_empty", 32'(dbg_state), 32'(ST_EMPTY));

    // extension table
    do_load("ld_h",  5'b00100, 32'h0000_0042, 32'h9ABC_1234, 32'hFFFF_9ABC);
    do_load("ld_hu", 5'b00010, 32'h0000_0040, 32'h1234_9ABC, 32'h0000_9ABC);
    do_load("ld_bu", 5'b01000, 32'h0000_0041, 32'h0000_F000, 32'h0000_00F0);
    do_load("ld_b+", 5'b10000, 32'h0000_0042, 32'h0071_0000, 32'h0000_0071);

    // non-load goes READY directly and writes the ALU result
    es_to_ms_valid = 1'b1; es_result = 32'h1357_9BDF; es_rf_we = 1'b1; es_rf_waddr = 5'd3;
    ws_allowin = 1'b0; #1; tick();
    es_to_ms_valid = 1'b0; #1;
    check("alu_state", 32'(dbg_state), 32'(ST_READY));
    check("alu_wdata", ms_rf_wdata, 32'h1357_9BDF);
    check("alu_resmem", 32'(ms_res_from_mem), 32'd0);
    ws_allowin = 1'b1; tick(); idle(); #1;

    // outstanding counter and req_block
    req_issue = 1'b1; #1; tick(); #1;
    check("cnt1_block", 32'(req_block), 32'd0);
    tick(); req_issue = 1'b0; #1;
    check("cnt2_count", 32'(dbg_count), 32'd2);
    check("cnt2_block", 32'(req_block), 32'd1);
    data_sram_data_ok = 1'b1; #1; tick(); idle(); #1;
    check("cnt_ok_block", 32'(req_block), 32'd0);
    check("cnt_ok_count", 32'(dbg_count), 32'd1);
    data_sram_data_ok = 1'b1; #1; tick(); idle(); #1;
    check("cnt_drain", 32'(dbg_count), 32'd0);

    // flush with two outstanding while in WAIT
    req_issue = 1'b1; #1; tick();
    idle(); drive_load(5'b00001, 32'h0000_0200, 5'd4); req_issue = 1'b1; #1; tick();
    idle(); #1;
    check("fl_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("fl_count", 32'(dbg_count), 32'd2);
    flush = 1'b1; #1; tick(); idle(); #1;
    check("fl_empty", 32'(dbg_state), 32'(ST_EMPTY));
    check("fl_discard", 32'(dbg_discard), 32'd2);
    check("fl_block", 32'(req_block), 32'd1);
    drive_load(5'b00001, 32'h0000_0300, 5'd6); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_0001; #1;
    check("fl_ok1_valid", 32'(ms_to_ws_valid), 32'd0);
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_0002; req_issue = 1'b1; #1;
    check("fl_ok2_state", 32'(dbg_state), 32'(ST_WAIT));
    check("fl_ok2_valid", 32'(ms_to_ws_valid), 32'd0);
    tick(); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; #1;
    check("fl_ok3_discard", 32'(dbg_discard), 32'd0);
    check("fl_ok3_valid", 32'(ms_to_ws_valid), 32'd1);
    check("fl_ok3_wdata", ms_rf_wdata, 32'h1234_5678);
    tick(); idle(); #1;
    check("fl_done_count", 32'(dbg_count), 32'd0);
    check("fl_done_state", 32'(dbg_state), 32'(ST_EMPTY));

    // flush + req_issue + data_ok together with count=1
    req_issue = 1'b1; #1; tick(); idle();
    flush = 1'b1; req_issue = 1'b1; data_sram_data_ok = 1'b1; #1; tick(); idle(); #1;
    check("fsame_discard", 32'(dbg_discard), 32'd1);
    check("fsame_count", 32'(dbg_count), 32'd1);
    data_sram_data_ok = 1'b1; #1; tick(); idle(); #1;
    check("fsame_drain_d", 32'(dbg_discard), 32'd0);
    check("fsame_drain_c", 32'(dbg_count), 32'd0);

    // exception instruction never waits for data
    drive_load(5'b00001, 32'h0000_0400, 5'd8); es_ex = 1'b1; ws_allowin = 1'b0; #1; tick();
    idle(); ws_allowin = 1'b0; #1;
    check("ex_state", 32'(dbg_state), 32'(ST_READY));
    check("ex_ms_ex", 32'(ms_ex), 32'd1);
    check("ex_valid", 32'(ms_to_ws_valid), 32'd1);
    check("ex_count", 32'(dbg_count), 32'd0);
    ws_allowin = 1'b1; #1; tick(); #1;
    check("ex_gone", 32'(ms_ex), 32'd0);

    // reset in the middle of WAIT, with a pending discard, overriding flush and transfer
    req_issue = 1'b1; #1; tick(); idle();
    drive_load(5'b00001, 32'h0000_0500, 5'd2); req_issue = 1'b1; #1; tick(); idle(); #1;
    check("mid_wait", 32'(dbg_state), 32'(ST_WAIT));
    resetn = 1'b0; flush = 1'b1; req_issue = 1'b1;
    drive_load(5'b00001, 32'h0000_0600, 5'd2); #1; tick(); idle(); #1;
    check("mrst_state", 32'(dbg_state), 32'(ST_EMPTY));
    check("mrst_count", 32'(dbg_count), 32'd0);
    check("mrst_discard", 32'(dbg_discard), 32'd0);
    check("mrst_rf_we", 32'(ms_rf_we), 32'd0);
    resetn = 1'b1; #1; tick(); #1;
    check("mrst_valid", 32'(ms_to_ws_valid), 32'd0);
    check("mrst_allowin", 32'(ms_allowin), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
